brute_sequencer: RTL and testbench
==================================

Name: brute_sequencer

Overview:
Sequences a brute-force sweep over a candidate range. For each candidate the block sends its bytes through a UART transmitter using a valid/ready handshake. It then waits for the byte-match detector's one-cycle match pulse, a non-matching received byte, or a timeout. The block records the first matching candidate and the attempt count. It sits between the host control registers, the UART TX, and the match detector on the RX side.

Parameters:
CAND_BYTES, 1, candidate width in bytes; sent least-significant byte first.
TIMEOUT_CYC, 100000, cycles to wait in WAIT_RESP before declaring no response; must be at least 1.
CNT_W, 32, width of the attempts counter.
MAX_RETRY, 2, resend limit per candidate on timeout; used only with BRUTE_RETRY_EN.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; begins a sweep when idle
abort  in  1  level/pulse; cancels the sweep
cand_min  in  8*CAND_BYTES  first candidate, sampled on an accepted start
cand_max  in  8*CAND_BYTES  last candidate, sampled on an accepted start
tx_data  out  8  byte offered to the UART TX
tx_valid  out  1  tx_data is valid
tx_ready  in  1  UART TX accepts the byte this cycle
rx_valid  in  1  one-cycle pulse: any byte received
match  in  1  one-cycle pulse: received byte equals the expected byte
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at the end of a sweep
found  out  1  the last sweep ended on a match
found_cand  out  8*CAND_BYTES  candidate that produced the match
attempts  out  CNT_W  candidates completed in the current/last sweep

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal candidate, byte index, and timer all 0.
- FSM states: IDLE, SEND, WAIT_RESP, NEXT, DONE.
- IDLE:
  - start=1 latches cand_min and cand_max, clears found, found_cand, and attempts, and sets busy.
  - If cand_min > cand_max, go to DONE with attempts=0. Otherwise go to SEND with byte index 0.
- SEND:
  - tx_valid=1; tx_data = candidate byte[index].
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
  - On tx_valid&&tx_ready: index increments. After the last byte, clear the timer and go to WAIT_RESP.
  - The next byte is presented the cycle after acceptance, so at most one byte is accepted per cycle.
- WAIT_RESP: the timer increments every cycle.
  - match=1: set found=1, found_cand=candidate, attempts+1, then go to DONE.
  - Otherwise rx_valid=1 (mismatching byte), or timer reaching TIMEOUT_CYC-1: go to NEXT.
  - If match and rx_valid occur in the same cycle, match wins.
- NEXT (one cycle):
  - attempts increments.
  - If candidate == cand_max, go to DONE with found=0. Otherwise increment the candidate and go to SEND at index 0.
  - The equality check is done before the increment, so an all-ones cand_max never wraps.
- DONE (one cycle): done=1 and busy=0 next cycle, then IDLE. found, found_cand, and attempts hold until the next accepted start.
- Ignored inputs:
  - start is ignored while busy.
  - match and rx_valid are ignored outside WAIT_RESP, including bytes still arriving during SEND.
- abort=1 in any non-IDLE state:
  - The next cycle is IDLE with tx_valid=0 and busy=0; done is not pulsed; found=0.
  - attempts keeps the count reached.
  - abort takes priority over start, match, and the handshake in the same cycle.
- attempts saturates at all-ones.
- Reset asserted mid-sweep returns everything to its reset values immediately (asynchronous).

Optional Feature:
Macro BRUTE_RETRY_EN.
- Defined:
  - A timeout in WAIT_RESP resends the same candidate (back to SEND at index 0, attempts unchanged) up to MAX_RETRY times.
  - A further timeout goes to NEXT.
  - A mismatching rx_valid still goes to NEXT immediately.
  - The retry counter clears on every NEXT and on every start.
- Undefined: a timeout goes straight to NEXT; no retry logic is synthesized.

Test Plan:
1. Basic hit: CAND_BYTES=1, cand_min=0x00, cand_max=0xFF, tx_ready=1.
   - Respond rx_valid with no match to 0x00..0x40; rx_valid+match on 0x41.
   - Expect tx_data sequence 0x00..0x41; done pulse; found=1, found_cand=0x41, attempts=66.
2. Exhaust with timeout: cand_min=0xFD, cand_max=0xFF, no responses, TIMEOUT_CYC=10.
   - Expect 3 sends roughly 12 cycles apart, then done with found=0 and attempts=3. No wrap to 0x00.
3. Backpressure and multi-byte: CAND_BYTES=2, cand_min=0x1234.
   - Hold tx_ready=0 for 5 cycles.
   - Expect tx_data=0x34 held stable, then 0x12, then WAIT_RESP.
4. Edge range and busy: cand_min=0x05 > cand_max=0x04 yields done after 2 cycles with attempts=0 and no tx_valid. A start pulse while busy is ignored.
5. Abort mid-SEND: abort while tx_valid=1.
   - Expect tx_valid=0 and busy=0 next cycle, no done pulse.
   - A later start sweeps from the new cand_min.
6. Retry (BRUTE_RETRY_EN, MAX_RETRY=2): no responses.
   - Expect each candidate sent 3 times before advancing; attempts increments once per candidate.
   - A mismatching rx_valid advances after a single send.

Source files
------------

// File: rtl/brute_sequencer.sv
// brute_sequencer: sweeps candidates cand_min..cand_max, sending each one LSB-first to the UART TX and waiting for match, mismatch or timeout.
// Latency: one cycle per accepted TX byte, then up to TIMEOUT_CYC cycles of response wait, then one cycle to advance.
// Backpressure: tx_data is held while tx_ready is low. Optional macro BRUTE_RETRY_EN resends a timed-out candidate up to MAX_RETRY times.
module brute_sequencer #(
  parameter int CAND_BYTES  = 1,
  parameter int TIMEOUT_CYC = 100000,
  parameter int CNT_W       = 32,
  parameter int MAX_RETRY   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [8*CAND_BYTES-1:0] cand_min,
  input  logic [8*CAND_BYTES-1:0] cand_max,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic                    rx_valid,
  input  logic                    match,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [8*CAND_BYTES-1:0] found_cand,
  output logic [CNT_W-1:0]        attempts
);

  localparam int CW = 8 * CAND_BYTES;
  localparam int IW = (CAND_BYTES > 1) ? $clog2(CAND_BYTES) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CAND_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, NEXT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cand;
  logic [CW-1:0]    cand_hi;
  logic [IW-1:0]    idx;
  logic [TW-1:0]    timer;
  logic             timeout;
  logic             retry_go;
  logic             abort_hit;
  logic [CNT_W-1:0] attempts_inc;

  assign timeout      = (timer == TMO_LAST);
  assign abort_hit    = abort && (state != IDLE);
  // attempts sticks at all-ones rather than wrapping
  assign attempts_inc = (&attempts) ? attempts : attempts + CNT_W'(1);

`ifdef BRUTE_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RW-1:0] retry_cnt;

  assign retry_go = timeout && (retry_cnt < RW'(MAX_RETRY));

  // Count resends of the current candidate; cleared whenever a new candidate or sweep begins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (state == IDLE || state == NEXT) begin
      retry_cnt <= '0;
    end else if (state == WAIT_RESP && !abort && !match && !rx_valid && retry_go) begin
      retry_cnt <= retry_cnt + RW'(1);
    end
  end
`else
  assign retry_go = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; abort overrides every other transition
  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    tx_data   = 8'(cand >> {idx, 3'b000});
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (cand_min > cand_max) ? DONE : SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && idx == LAST_IDX) begin
          state_nxt = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (match) begin
          state_nxt = DONE;
        end else if (rx_valid) begin
          state_nxt = NEXT;
        end else if (timeout) begin
          state_nxt = retry_go ? SEND : NEXT;
        end
      end
      NEXT: begin
        state_nxt = (cand == cand_hi) ? DONE : SEND;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort_hit) begin
      state_nxt = IDLE;
    end
  end

  // Candidate, byte index, timer and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand       <= '0;
      cand_hi    <= '0;
      idx        <= '0;
      timer      <= '0;
      found      <= 1'b0;
      found_cand <= '0;
      attempts   <= '0;
    end else if (abort_hit) begin
      found <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cand       <= cand_min;
            cand_hi    <= cand_max;
            idx        <= '0;
            found      <= 1'b0;
            found_cand <= '0;
            attempts   <= '0;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              timer <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        WAIT_RESP: begin
          timer <= timer + TW'(1);
          if (match) begin
            found      <= 1'b1;
            found_cand <= cand;
            attempts   <= attempts_inc;
          end
        end
        NEXT: begin
          attempts <= attempts_inc;
          // compare before incrementing so an all-ones cand_max never wraps
          if (cand != cand_hi) begin
            cand <= cand + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brute_sequencer.sv
// Directed bench for brute_sequencer: 2-byte candidates, 10-cycle timeout, 8-bit attempt counter.
// Inputs are driven and outputs sampled on the falling clock edge.
// Builds with or without BRUTE_RETRY_EN; expected send counts and spacing adapt to it.
module tb_brute_sequencer;

`ifdef BRUTE_RETRY_EN
  localparam int REPS = 3;
`else
  localparam int REPS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cand_min = '0;
  logic [15:0] cand_max = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic        match = 1'b0;
  logic        busy;
  logic        done;
  logic        found;
  logic [15:0] found_cand;
  logic [7:0]  attempts;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  brute_sequencer #(
    .CAND_BYTES (2),
    .TIMEOUT_CYC(10),
    .CNT_W      (8),
    .MAX_RETRY  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cand_min  (cand_min),
    .cand_max  (cand_max),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .match     (match),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .found_cand(found_cand),
    .attempts  (attempts)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plays the host side of one sweep after start has been raised: checks every
  // candidate value and its spacing, optionally answers each candidate with rx_valid
  // (plus match on hit), and returns at the done pulse or when the budget expires.
  task automatic run_sweep(input logic [15:0] lo, input bit respond, input logic [15:0] hit,
                           input int budget, output int nsent);
    int          nbyte;
    int          reps;
    int          last_cyc;
    int          exp_gap;
    bit          pend;
    bit          fin;
    logic [7:0]  b0;
    logic [15:0] got;
    nsent    = 0;
    nbyte    = 0;
    last_cyc = 0;
    pend     = 1'b0;
    fin      = 1'b0;
    b0       = '0;
    got      = '0;
    reps     = respond ? 1 : REPS;
    tx_ready = 1'b1;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      @(negedge clk);
      start    = 1'b0;
      rx_valid = 1'b0;
      match    = 1'b0;
      if (pend) begin
        rx_valid = 1'b1;
        match    = (got == hit);
        pend     = 1'b0;
      end
      if (done) begin
        fin = 1'b1;
      end else if (tx_valid) begin
        if (nbyte == 0) begin
          b0 = tx_data;
          if (nsent > 0) begin
            exp_gap = respond ? 4 : ((nsent % reps) != 0 ? 12 : 13);
            chk("send_gap", cyc - last_cyc, exp_gap);
          end
          last_cyc = cyc;
          nbyte    = 1;
        end else begin
          got = {tx_data, b0};
          chk("cand_seq", got, lo + 16'(nsent / reps));
          nsent++;
          nbyte = 0;
          pend  = respond;
        end
      end
    end
    chk("done_seen", fin, 1);
    rx_valid = 1'b0;
    match    = 1'b0;
  endtask

  initial begin
    int n;

    // reset state while rst is held
    #2;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_found_cand", found_cand, 0);
    chk("rst_attempts", attempts, 0);
    @(negedge clk);
    rst = 1'b0;

    // basic hit: mismatch on 0x00..0x40, match on 0x41
    @(negedge clk);
    cand_min = 16'h0000;
    cand_max = 16'h00FF;
    start    = 1'b1;
    run_sweep(16'h0000, 1'b1, 16'h0041, 400, n);
    chk("hit_nsent", n, 66);
    chk("hit_found", found, 1);
    chk("hit_found_cand", found_cand, 16'h0041);
    chk("hit_attempts", attempts, 66);
    chk("hit_busy_in_done", busy, 1);
    @(negedge clk);
    chk("hit_done_one_cycle", done, 0);
    chk("hit_busy_after", busy, 0);
    chk("hit_found_holds", found, 1);

    // exhaust to all-ones with timeouts only; must not wrap
    @(negedge clk);
    cand_min = 16'hFFFD;
    cand_max = 16'hFFFF;
    start    = 1'b1;
    run_sweep(16'hFFFD, 1'b0, 16'h0000, 200, n);
    chk("exh_nsent", n, 3 * REPS);
    chk("exh_found", found, 0);
    chk("exh_found_cand", found_cand, 0);
    chk("exh_attempts", attempts, 3);
    @(negedge clk);
    chk("exh_no_wrap_tx", tx_valid, 0);
    chk("exh_busy_after", busy, 0);

    // backpressure on a 2-byte candidate; rx during SEND must be ignored
    @(negedge clk);
    cand_min = 16'h1234;
    cand_max = 16'h1234;
    tx_ready = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b1;
    match    = 1'b1;
    chk("bp_valid", tx_valid, 1);
    chk("bp_byte0", tx_data, 8'h34);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      match    = 1'b0;
      chk("bp_hold_data", tx_data, 8'h34);
      chk("bp_hold_valid", tx_valid, 1);
    end
    chk("bp_match_ignored", found, 0);
    @(negedge clk);
    tx_ready = 1'b1;
    chk("bp_byte0_last", tx_data, 8'h34);
    @(negedge clk);
    chk("bp_byte1", tx_data, 8'h12);
    chk("bp_byte1_valid", tx_valid, 1);
    @(negedge clk);
    chk("bp_wait_valid", tx_valid, 0);
    chk("bp_wait_busy", busy, 1);
    rx_valid = 1'b1;
    match    = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    match    = 1'b0;
    chk("bp_done", done, 1);
    chk("bp_found", found, 1);
    chk("bp_found_cand", found_cand, 16'h1234);
    chk("bp_attempts", attempts, 1);
    @(negedge clk);
    chk("bp_done_clear", done, 0);
    chk("bp_idle", busy, 0);

    // empty range: straight to done; start while busy is ignored
    @(negedge clk);
    cand_min = 16'h0005;
    cand_max = 16'h0004;
    start    = 1'b1;
    @(negedge clk);
    chk("empty_done", done, 1);
    chk("empty_tx_valid", tx_valid, 0);
    chk("empty_attempts", attempts, 0);
    chk("empty_found_cleared", found, 0);
    cand_min = 16'h0000;
    cand_max = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    chk("empty_busy_start_ignored", busy, 0);
    chk("empty_done_clear", done, 0);
    chk("empty_tx_after", tx_valid, 0);

    // abort mid-SEND, with a concurrent handshake
    @(negedge clk);
    cand_min = 16'h0010;
    cand_max = 16'h0020;
    tx_ready = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    chk("abort_send_byte", tx_data, 8'h10);
    cand_min = 16'h0099;
    @(negedge clk);
    start = 1'b0;
    chk("abort_start_ignored", tx_data, 8'h10);
    chk("abort_busy_before", busy, 1);
    abort    = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", done, 0);
    chk("abort_attempts", attempts, 0);
    cand_min = 16'h0030;
    cand_max = 16'h0030;
    start    = 1'b1;
    run_sweep(16'h0030, 1'b1, 16'h0030, 50, n);
    chk("resweep_nsent", n, 1);
    chk("resweep_found", found, 1);
    chk("resweep_found_cand", found_cand, 16'h0030);
    chk("resweep_attempts", attempts, 1);

    // 300 mismatching candidates: attempts saturates at 0xFF
    @(negedge clk);
    cand_min = 16'h0000;
    cand_max = 16'h012B;
    start    = 1'b1;
    run_sweep(16'h0000, 1'b1, 16'hFFFF, 1400, n);
    chk("sat_nsent", n, 300);
    chk("sat_attempts", attempts, 8'hFF);
    chk("sat_found", found, 0);

    // asynchronous reset in the middle of SEND
    @(negedge clk);
    cand_min = 16'h0050;
    cand_max = 16'h0060;
    tx_ready = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("arst_pre_valid", tx_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_stays_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
